// File: rtl/serial_tx_framer_pkg.sv
// Shared definitions for the serial transmit framer: FSM state encoding,
// line levels and the frame parity helper.
package serial_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  localparam int unsigned MAX_DATA_W = 16;

  // Payload is zero-extended by the caller, so the pad bits do not disturb the XOR.
  function automatic logic frame_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_tx_framer_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the terminal count.
// Held at zero while clr_i is asserted so every bit period starts aligned.
module tx_bit_timer
  import serial_tx_framer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT > 1 ? CLKS_PER_BIT : 2);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || bit_tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB-first,
// optional parity bit, one stop bit, with a registered idle-high output line.
module serial_tx_framer
  import serial_tx_framer_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              bit_tick;
  logic              timer_clr;
  logic              accept;

  assign timer_clr = (state_q == ST_IDLE);
  assign accept    = tx_valid & tx_ready;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (timer_clr),
    .bit_tick_o(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= IDLE_LVL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  if (bit_tick) state_d = ST_DATA;
      ST_DATA:   if (bit_tick && bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
      ST_STOP:   if (bit_tick) state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    if (accept) begin
      shift_d = tx_data;
      par_d   = frame_parity(MAX_DATA_W'(tx_data), PARITY_ODD != 0);
    end else if (state_q == ST_DATA && bit_tick) begin
      shift_d = shift_q >> 1;
      bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + BW'(1);
    end
  end

  // The line level is decoded from the next state so txd comes straight off a flop.
  always_comb begin
    txd_d = IDLE_LVL;
    unique case (state_d)
      ST_IDLE:   txd_d = IDLE_LVL;
      ST_START:  txd_d = START_LVL;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_d;
      ST_STOP:   txd_d = IDLE_LVL;
      default:   txd_d = IDLE_LVL;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == ST_IDLE) || (state_q == ST_STOP && bit_tick);
    tx_done  = (state_q == ST_STOP) && bit_tick;
    tx_busy  = (state_q != ST_IDLE);
    txd      = txd_q;
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: three parameterisations checked every cycle
// against a frame-position model, plus literal expectations for known frames.
module tb_serial_tx_framer;

  logic       clk;
  logic [2:0] rst_s;
  logic [2:0] valid_s;
  logic [7:0] data_s [3];
  logic [2:0] txd_w, ready_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  serial_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .tx_data(data_s[0]), .tx_valid(valid_s[0]),
    .tx_ready(ready_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  serial_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .tx_data(data_s[1]), .tx_valid(valid_s[1]),
    .tx_ready(ready_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  serial_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .tx_data(data_s[2]), .tx_valid(valid_s[2]),
    .tx_ready(ready_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int pen_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic logic odd_of(input int k);
    return (k == 1);
  endfunction

  function automatic int flen_of(input int k);
    return (2 + 8 + pen_of(k)) * cpb_of(k);
  endfunction

  // Frame bit list, index 0 = start bit; unused upper positions stay high.
  function automatic logic [15:0] build_frame(input int k, input logic [7:0] d);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (pen_of(k) != 0) f[9] = ((ones % 2) == 1) ^ odd_of(k);
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: position of the frame in flight, if any.
  logic        synced [3];
  logic        active [3];
  int          tpos   [3];
  logic [15:0] fbits  [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      synced[k] = 1'b0;
      active[k] = 1'b0;
      tpos[k]   = 0;
      fbits[k]  = '1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic e_txd, e_busy, e_ready, e_done, last;
      last    = active[k] && (tpos[k] == flen_of(k) - 1);
      e_txd   = active[k] ? fbits[k][tpos[k] / cpb_of(k)] : 1'b1;
      e_busy  = active[k];
      e_ready = !active[k] || last;
      e_done  = last;
      if (synced[k]) begin
        chk($sformatf("k%0d txd", k),      32'(txd_w[k]),   32'(e_txd));
        chk($sformatf("k%0d tx_busy", k),  32'(busy_w[k]),  32'(e_busy));
        chk($sformatf("k%0d tx_ready", k), 32'(ready_w[k]), 32'(e_ready));
        chk($sformatf("k%0d tx_done", k),  32'(done_w[k]),  32'(e_done));
      end
      if (rst_s[k]) begin
        active[k] = 1'b0;
        synced[k] = 1'b1;
      end else if (synced[k]) begin
        if (active[k]) begin
          tpos[k]++;
          if (tpos[k] == flen_of(k)) active[k] = 1'b0;
        end
        if (valid_s[k] && e_ready) begin
          active[k] = 1'b1;
          tpos[k]   = 0;
          fbits[k]  = build_frame(k, data_s[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one frame, scramble tx_data after acceptance, capture mid-bit samples.
  task automatic send_capture(input int k, input logic [7:0] d, input logic [15:0] exp_bits,
                              input int exp_done, input string name);
    logic [15:0] cap;
    int nbits, cpb, len, done_cyc, done_cnt;
    cpb = cpb_of(k);
    len = flen_of(k);
    nbits = len / cpb;
    cap = '1;
    done_cyc = -1;
    done_cnt = 0;
    valid_s[k] = 1'b1;
    data_s[k]  = d;
    tick();
    valid_s[k] = 1'b0;
    data_s[k]  = ~d;
    for (int c = 1; c <= len + 3; c++) begin
      if (c <= len && ((c - 1) % cpb) == cpb / 2) cap[(c-1)/cpb] = txd_w[k];
      if (done_w[k]) begin
        done_cyc = c;
        done_cnt++;
      end
      if (c == len) chk({name, " ready_at_end"}, 32'(ready_w[k]), 32'd1);
      if (c == 2) data_s[k] = 8'h5A;
      tick();
    end
    chk({name, " bits"}, 32'(cap & ((16'd1 << nbits) - 16'd1)), 32'(exp_bits));
    chk({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({name, " done_count"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $finish;
  end

  initial begin
    int busy_gaps, done_a, done_b, idle_done;
    logic [15:0] cap2;
    rst_s   = 3'b111;
    valid_s = 3'b111;
    for (int k = 0; k < 3; k++) data_s[k] = 8'hC3;

    // Reset with tx_valid asserted: nothing may start.
    for (int r = 0; r < 3; r++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("k%0d reset txd", k),   32'(txd_w[k]),   32'd1);
        chk($sformatf("k%0d reset ready", k), 32'(ready_w[k]), 32'd1);
        chk($sformatf("k%0d reset busy", k),  32'(busy_w[k]),  32'd0);
        chk($sformatf("k%0d reset done", k),  32'(done_w[k]),  32'd0);
      end
    end
    rst_s   = 3'b000;
    valid_s = 3'b000;
    tick();
    tick();

    send_capture(0, 8'hA5, 16'b1_0_10100101_0, 44, "A5_even");

    // Back-to-back 00 then FF with tx_valid held.
    busy_gaps = 0;
    done_a = -1;
    done_b = -1;
    cap2 = '1;
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h00;
    tick();
    data_s[0] = 8'hFF;
    for (int c = 1; c <= 92; c++) begin
      if (c == 45) begin
        valid_s[0] = 1'b0;
        chk("b2b start_at_45", 32'(txd_w[0]), 32'd0);
      end
      if (c == 44) chk("b2b stop_at_44", 32'(txd_w[0]), 32'd1);
      if (c >= 45 && c <= 88 && ((c - 45) % 4) == 2) cap2[(c-45)/4] = txd_w[0];
      if (c <= 88 && !busy_w[0]) busy_gaps++;
      if (done_w[0]) begin
        if (done_a < 0) done_a = c;
        else done_b = c;
      end
      tick();
    end
    chk("b2b busy_gaps", 32'(busy_gaps), 32'd0);
    chk("b2b first_done", 32'(done_a), 32'd44);
    chk("b2b second_done", 32'(done_b), 32'd88);
    chk("b2b FF_bits", 32'(cap2 & 16'h07FF), 32'(16'b1_0_11111111_0));

    // Reset at cycle 18 of a 3C frame.
    idle_done = 0;
    valid_s[0] = 1'b1;
    data_s[0]  = 8'h3C;
    tick();
    valid_s[0] = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (done_w[0]) idle_done++;
      tick();
    end
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    chk("rst_mid txd", 32'(txd_w[0]), 32'd1);
    chk("rst_mid ready", 32'(ready_w[0]), 32'd1);
    chk("rst_mid busy", 32'(busy_w[0]), 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (done_w[0]) idle_done++;
      tick();
    end
    chk("rst_mid no_done", 32'(idle_done), 32'd0);
    send_capture(0, 8'h81, 16'b1_0_10000001_0, 44, "81_after_rst");

    send_capture(1, 8'h01, 16'b1_0_00000001_0, 44, "01_odd");
    send_capture(1, 8'h03, 16'b1_1_00000011_0, 44, "03_odd");
    send_capture(2, 8'h96, 16'b1_10010110_0, 10, "96_cpb1");

    // Randomised traffic, resets and payload churn on all three instances.
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 3; k++) begin
        rst_s[k]   = ($urandom_range(0, 299) == 0);
        valid_s[k] = ($urandom_range(0, 3) != 0);
        data_s[k]  = 8'($urandom);
      end
      tick();
    end
    rst_s   = 3'b000;
    valid_s = 3'b000;
    repeat (60) tick();

    summary();
    $finish;
  end

endmodule
